byte_serializer: RTL
====================

BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter SYM_W, default 2: bits per output symbol; legal values 1, 2, 4, 8.
REQ-002 Parameter MSB_FIRST, default 1: 1 = symbols taken from bit 7 downward; 0 = from bit 0 upward.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  8  byte to serialize.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_sym  output  SYM_W  current symbol for the mapper.
REQ-009 out_valid  output  1  out_sym valid.
REQ-010 out_ready  input  1  downstream accepts out_sym this cycle.
REQ-011 out_last  output  1  out_sym is the last symbol of its byte.
REQ-012 busy  output  1  a byte is held in the buffer or the shifter.

Function
REQ-013 An input handshake occurs when in_valid and in_ready are both high; an output handshake occurs when out_valid and out_ready are both high.
REQ-014 Each byte is emitted as NSYM = 8/SYM_W symbols, in byte order, with no symbol dropped or repeated.
REQ-015 Datapath: one-byte hold buffer (buf, buf_valid) feeding an 8-bit shift register (sh) with a symbol counter cnt of width clog2(NSYM), minimum 1 bit.
REQ-016 FSM states: IDLE (shifter empty) and SHIFT (shifter holds a byte).
REQ-017 IDLE -> SHIFT when buf_valid=1: sh <= buf, cnt <= 0, buf_valid cleared unless refilled in the same cycle.
REQ-018 In SHIFT, on an output handshake with cnt < NSYM-1: shift sh by SYM_W toward the emit end and increment cnt.
REQ-019 In SHIFT, on an output handshake with cnt = NSYM-1: if buf_valid, reload sh from buf, set cnt <= 0, and stay in SHIFT; otherwise go to IDLE.
REQ-020 out_sym = sh[7:8-SYM_W] when MSB_FIRST=1, else sh[SYM_W-1:0].
REQ-021 out_valid = (state == SHIFT).
REQ-022 out_last = out_valid and (cnt == NSYM-1).
REQ-023 in_ready = !buf_valid, or buf is being transferred into sh this cycle; this permits a combinational out_ready -> in_ready path.
REQ-024 Simultaneous buf drain and input handshake: buf takes the new byte and buf_valid stays 1.
REQ-025 Latency: a byte accepted at edge t gives out_valid=1 with its first symbol after edge t+1.
REQ-026 Throughput: with out_ready held at 1 and in_valid held at 1, out_valid stays high continuously for every SYM_W, including SYM_W=8.
REQ-027 While out_valid=1 and out_ready=0, out_sym, out_last, sh and cnt hold.
REQ-028 busy = buf_valid or (state == SHIFT).

Reset
REQ-029 While reset=1: state=IDLE, sh=0, cnt=0, buf=0, buf_valid=0, out_valid=0, out_last=0, out_sym=0, busy=0, in_ready=0.
REQ-030 in_ready rises in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-byte discards buffered and partially shifted data; no symbol of that byte appears after reset.

Structure
REQ-032 The shared package ofdm_pkg holds the FSM state enum ser_state_t (IDLE, SHIFT) and the SYM_W legality check constant.
REQ-033 The hold buffer is the sub-module byte_hold_buf, with load enable, clear and valid flag.
REQ-034 The FSM, counter and shifter are implemented in byte_serializer.

Verification
REQ-035 SYM_W=2, MSB_FIRST=1, in_data=8'hB4, out_ready=1 -> out_sym 2,3,1,0 on consecutive cycles; out_last only on the 4th symbol.
REQ-036 SYM_W=1, MSB_FIRST=0, in_data=8'h01 -> out_sym 1,0,0,0,0,0,0,0.
REQ-037 SYM_W=8, bytes 8'h11, 8'h22, 8'h33 back-to-back, out_ready=1 -> out_valid high for 3 consecutive cycles with 11,22,33 and out_last high on each.
REQ-038 SYM_W=4, in_data=8'hA5, out_ready=0 for 5 cycles after out_valid rises -> out_sym holds A; after release, A then 5.
REQ-039 Reset pulsed during the 2nd symbol of 8'hF0 (SYM_W=2) -> out_valid=0 immediately and no symbol of 8'hF0 afterwards; next byte 8'h0F -> 0,0,3,3.
REQ-040 Buffer full and out_ready=0 -> in_ready=0 and the offered byte is not lost; it is accepted once the shifter drains.

Source files
------------

// File: rtl/ofdm_pkg.sv
// Shared definitions for the symbol-path blocks.
//   ser_state_t  : serializer FSM states (IDLE = shifter empty, SHIFT = shifter holds a byte)
//   SYM_W_LEGAL  : bit w is set when w is a legal symbol width (1, 2, 4, 8)
//   sym_w_ok()   : elaboration-time legality test against SYM_W_LEGAL
package ofdm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam logic [8:0] SYM_W_LEGAL = 9'b1_0001_0110;

  function automatic logic sym_w_ok(input int unsigned w);
    return (w < 9) && SYM_W_LEGAL[w[3:0]];
  endfunction

endpackage

// File: rtl/byte_hold_buf.sv
// One-byte hold buffer in front of the serializer shifter.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture din and mark valid (wins over clear)
//   clear      : drop the valid flag (byte moved on)
//   din        : byte to capture
//   dout       : held byte
//   valid      : dout holds a byte not yet taken
module byte_hold_buf (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       clear,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       valid
);

  // load has priority so a drain and refill in the same cycle keeps valid set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_serializer.sv
// Splits bytes into SYM_W-bit symbols for the mapper, 8/SYM_W symbols per byte.
//   SYM_W     : bits per symbol (1, 2, 4 or 8)
//   MSB_FIRST : 1 = emit from bit 7 downward, 0 = from bit 0 upward
//   clk, reset: clock, asynchronous active-high reset
//   in_data / in_valid / in_ready    : byte input handshake
//   out_sym / out_valid / out_ready  : symbol output handshake
//   out_last  : current symbol is the final one of its byte
//   busy      : a byte is held in the buffer or the shifter
module byte_serializer
  import ofdm_pkg::*;
#(
  parameter int unsigned SYM_W     = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SYM_W-1:0] out_sym,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned     NSYM     = 8 / SYM_W;
  localparam int unsigned     CNT_W    = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSYM - 1);

  if (!sym_w_ok(SYM_W)) begin : g_bad_sym_w
    $error("byte_serializer: SYM_W must be 1, 2, 4 or 8");
  end

  ser_state_t       state, state_d;
  logic [7:0]       sh, sh_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic [7:0] buf_data;
  logic       buf_valid;
  logic       load_sh;
  logic       in_hs;
  logic       out_hs;
  logic       at_last;

  assign out_valid = (state == SHIFT);
  assign at_last   = (cnt == CNT_LAST);
  assign out_hs    = out_valid && out_ready;
  assign out_last  = out_valid && at_last;
  assign busy      = buf_valid || out_valid;

  // Buffer moves into the shifter when the shifter is empty or is emitting
  // its final symbol this cycle.
  assign load_sh  = buf_valid && ((state == IDLE) || (out_hs && at_last));
  // Freeing the buffer in the same cycle lets a new byte in without a bubble,
  // at the cost of a combinational out_ready -> in_ready path.
  assign in_ready = !reset && (!buf_valid || load_sh);
  assign in_hs    = in_valid && in_ready;

  assign out_sym = MSB_FIRST ? sh[7 -: SYM_W] : sh[SYM_W-1:0];

  byte_hold_buf u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (in_hs),
    .clear (load_sh),
    .din   (in_data),
    .dout  (buf_data),
    .valid (buf_valid)
  );

  always_comb begin
    state_d = state;
    sh_d    = sh;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (buf_valid) begin
          state_d = SHIFT;
          sh_d    = buf_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (out_hs) begin
          if (!at_last) begin
            sh_d  = MSB_FIRST ? (sh << SYM_W) : (sh >> SYM_W);
            cnt_d = cnt + 1'b1;
          end else if (buf_valid) begin
            sh_d  = buf_data;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      sh    <= sh_d;
      cnt   <= cnt_d;
    end
  end

endmodule
